// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous signal over a programmable clk_in window
module freq_meter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              sig_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CNT_W-1:0]  count_out,
    output logic              valid,
    output logic              busy,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic sync_prev, rise, accept, sat, ovf, ovf_nxt, enter_done;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0] edge_cnt, edge_nxt;

    assign rise       = sync[SYNC_STAGES-1] & ~sync_prev;
    assign accept     = state == IDLE && start;
    assign sat        = &edge_cnt;
    assign edge_nxt   = (state == MEASURE && rise && !sat) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign ovf_nxt    = ovf | (state == MEASURE && rise && sat);
    assign enter_done = state_nxt == DONE && state != DONE;

    always_ff @(posedge clk_in) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = gate_len == '0 ? DONE : MEASURE;
        else if (state == MEASURE) state_nxt = gate_cnt == GATE_W'(1) ? DONE : MEASURE;
        else if (state != IDLE) state_nxt = IDLE;
        busy  = state == MEASURE;
        valid = state == DONE;
    end

    // a zero-length window publishes a clean zero rather than a stale edge count
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync      <= '0;
            sync_prev <= 1'b0;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            ovf       <= 1'b0;
            count_out <= '0;
            overflow  <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], sig_in};
            sync_prev <= sync[SYNC_STAGES-1];
            if (accept) begin
                gate_cnt <= gate_len;
                edge_cnt <= '0;
                ovf      <= 1'b0;
            end else if (state == MEASURE) begin
                gate_cnt <= gate_cnt - GATE_W'(1);
                edge_cnt <= edge_nxt;
                ovf      <= ovf_nxt;
            end
            if (enter_done) begin
                count_out <= accept ? '0 : edge_nxt;
                overflow  <= accept ? 1'b0 : ovf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of freq_meter timing, counting, saturation and abort behaviour
module tb_freq_meter;
    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        sig_in = 1'b0;
    logic        start = 1'b0;
    logic [15:0] gate_len = '0;
    logic [15:0] count_out;
    logic        valid, busy, overflow;
    logic [3:0]  s_count;
    logic        s_valid, s_busy, s_overflow;
    int          errors = 0;
    int          checks = 0;
    int          mode = 0;
    logic [31:0] ph = '0;

    always #5 clk_in = ~clk_in;

    freq_meter dut (
        .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .start(start), .gate_len(gate_len),
        .count_out(count_out), .valid(valid), .busy(busy), .overflow(overflow)
    );

    freq_meter #(.CNT_W(4)) dut_s (
        .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .start(start), .gate_len(gate_len),
        .count_out(s_count), .valid(s_valid), .busy(s_busy), .overflow(s_overflow)
    );

    // mode 0: low, 1: high, 2: period 2, 3: period 4 (2 high / 2 low)
    initial begin
        forever begin
            @(posedge clk_in);
            #3;
            ph = ph + 1;
            sig_in = mode == 1 ? 1'b1 : mode == 2 ? ph[0] : mode == 3 ? ph[1] : 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic run_window(input logic [15:0] gl, output int lat, output int busy_n);
        tick(1);
        start = 1'b1;
        gate_len = gl;
        tick(1);
        start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!valid && lat < 300) begin
            busy_n += int'(busy);
            tick(1);
            lat++;
        end
        if (!valid) begin
            errors++;
            checks++;
            $display("FAIL window_timeout: valid not seen within %0d cycles", lat);
        end
    endtask

    task automatic test_reset;
        mode = 0;
        reset = 1'b1;
        tick(3);
        checks++;
        if ({count_out, valid, busy, overflow} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got count=%0d v=%b b=%b o=%b, want all 0", count_out, valid, busy, overflow);
        end
        checks++;
        if ({s_count, s_valid, s_busy, s_overflow} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs_small: got count=%0d v=%b b=%b o=%b, want all 0", s_count, s_valid, s_busy, s_overflow);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic;
        int lat, bn;
        mode = 3;
        tick(8);
        run_window(16'd64, lat, bn);
        checks++;
        if (lat !== 64) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want 64", lat);
        end
        checks++;
        if (bn !== 64) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want 64", bn);
        end
        checks++;
        if (count_out !== 16'd16 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got count=%0d o=%b b=%b, want 16 0 0", count_out, overflow, busy);
        end
        tick(1);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_pulse: got valid=%b after DONE, want 0", valid);
        end
        tick(5);
        checks++;
        if (count_out !== 16'd16) begin
            errors++;
            $display("FAIL basic_hold: got %0d, want 16", count_out);
        end
    endtask

    task automatic test_abort;
        int nv, lat, bn;
        mode = 3;
        tick(1);
        start = 1'b1;
        gate_len = 16'd100;
        tick(1);
        start = 1'b0;
        tick(49);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_mid: got %b, want 1", busy);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if ({count_out, valid, busy, overflow} !== 19'd0) begin
            errors++;
            $display("FAIL abort_outputs: got count=%0d v=%b b=%b o=%b, want all 0", count_out, valid, busy, overflow);
        end
        nv = 0;
        repeat (120) begin
            tick(1);
            nv += int'(valid);
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d pulses, want 0", nv);
        end
        run_window(16'd64, lat, bn);
        checks++;
        if (lat !== 64 || count_out !== 16'd16) begin
            errors++;
            $display("FAIL abort_restart: got lat=%0d count=%0d, want 64 16", lat, count_out);
        end
    endtask

    task automatic test_zero_gate;
        tick(1);
        start = 1'b1;
        gate_len = 16'd0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy_idle: got %b, want 0", busy);
        end
        tick(1);
        start = 1'b0;
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || count_out !== 16'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got v=%b b=%b count=%0d o=%b, want 1 0 0 0", valid, busy, count_out, overflow);
        end
        tick(1);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: got v=%b b=%b, want 0 0", valid, busy);
        end
    endtask

    task automatic test_overflow;
        int lat, bn;
        mode = 2;
        tick(4);
        run_window(16'd64, lat, bn);
        checks++;
        if (s_count !== 4'd15 || s_overflow !== 1'b1 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_small: got count=%0d o=%b v=%b, want 15 1 1", s_count, s_overflow, s_valid);
        end
        checks++;
        if (count_out !== 16'd32 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_wide: got count=%0d o=%b, want 32 0", count_out, overflow);
        end
        mode = 0;
        tick(4);
        run_window(16'd64, lat, bn);
        checks++;
        if (s_count !== 4'd0 || s_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got count=%0d o=%b, want 0 0", s_count, s_overflow);
        end
    endtask

    task automatic test_ignore_start;
        int first, pulses, bn;
        mode = 3;
        tick(4);
        start = 1'b1;
        gate_len = 16'd32;
        tick(1);
        start = 1'b0;
        first = 0;
        pulses = 0;
        bn = 0;
        for (int c = 1; c <= 60; c++) begin
            if (valid) begin
                pulses++;
                if (first == 0) first = c;
            end
            bn += int'(busy);
            if (c == 5) begin
                start = 1'b1;
                gate_len = 16'd5;
            end
            if (c == 20) start = 1'b0;
            tick(1);
        end
        checks++;
        if (first !== 33 || pulses !== 1 || bn !== 32) begin
            errors++;
            $display("FAIL ignore_start: got first=%0d pulses=%0d busy=%0d, want 33 1 32", first, pulses, bn);
        end
        checks++;
        if (count_out !== 16'd8) begin
            errors++;
            $display("FAIL ignore_count: got %0d, want 8", count_out);
        end
    endtask

    task automatic test_high_through_reset;
        mode = 1;
        tick(5);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(9);
        start = 1'b1;
        gate_len = 16'd20;
        tick(1);
        start = 1'b0;
        for (int c = 0; c < 40 && !valid; c++) tick(1);
        checks++;
        if (valid !== 1'b1 || count_out !== 16'd0 || s_count !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL high_reset: got v=%b count=%0d small=%0d o=%b, want 1 0 0 0", valid, count_out, s_count, overflow);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_zero_gate();
        test_overflow();
        test_ignore_start();
        test_high_through_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
